// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the memory port arbiter slice.
//   state_t : arbiter sequencing state (idle / waiting for read data)
//   owner_t : which requester owns the outstanding read
//   LAT_CNT_WIDTH : width of the read-latency down-counter (latencies 1..15)
package mem_arb_pkg;

  localparam int LAT_CNT_WIDTH = 4;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_DM   = 2'b10
  } owner_t;

  // The counter reaches zero exactly on the response cycle, so it is
  // preloaded with one less than the read latency.
  function automatic logic [LAT_CNT_WIDTH-1:0] lat_preload(input int unsigned lat);
    return LAT_CNT_WIDTH'(lat - 32'd1);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer
//   Loadable down-counter with a done flag, used to time the memory read
//   latency.
//   clk, rst   : clock and synchronous active-high reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to preload
//   done       : counter is at zero
module mem_arb_timer
  import mem_arb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [LAT_CNT_WIDTH-1:0] load_val,
  output logic                     done
);

  logic [LAT_CNT_WIDTH-1:0] cnt_q;
  logic [LAT_CNT_WIDTH-1:0] cnt_d;

  // Next count: load, else decrement until zero and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the fetch requester (if_*) and
//   the load/store requester (dm_*). Data has fixed priority over fetch,
//   except that after STARVE_LIMIT consecutive data grants with fetch
//   waiting, fetch wins. One transaction is outstanding at a time; reads
//   return MEM_LATENCY cycles after issue, stores acknowledge one cycle
//   after issue. A new grant may be made in the cycle a read completes.
//   if_req_*  / if_resp_*  : fetch request / response
//   dm_req_*  / dm_resp_*  : load/store request / response
//   mem_*                  : memory port (strobes and address valid only in
//                            the grant cycle; read data sampled at completion)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_resp_valid,
  output logic [DATA_WIDTH-1:0] if_resp_data,
  input  logic                  dm_req_valid,
  input  logic                  dm_req_write,
  input  logic [ADDR_WIDTH-1:0] dm_req_addr,
  input  logic [DATA_WIDTH-1:0] dm_req_wdata,
  output logic                  dm_req_ready,
  output logic                  dm_resp_valid,
  output logic [DATA_WIDTH-1:0] dm_resp_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  logic [SC_W-1:0] starve_q, starve_d;
  logic            store_ack_q, store_ack_d;
  // High for the cycle right after reset; grants are held off so every
  // output stays at zero through that cycle.
  logic            init_q, init_d;

  logic timer_load;
  logic timer_done;
  logic read_done;
  logic grant_en;
  logic grant_if;
  logic grant_dm;

  mem_arb_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (lat_preload(MEM_LATENCY)),
    .done     (timer_done)
  );

  // Grant selection, response routing, memory port drive and next state.
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    starve_d         = starve_q;
    store_ack_d      = 1'b0;
    init_d           = 1'b0;
    timer_load       = 1'b0;
    read_done        = 1'b0;
    grant_en         = 1'b0;
    grant_if         = 1'b0;
    grant_dm         = 1'b0;
    if_req_ready     = 1'b0;
    if_resp_valid    = 1'b0;
    if_resp_data     = '0;
    dm_req_ready     = 1'b0;
    dm_resp_valid    = 1'b0;
    dm_resp_data     = '0;
    mem_addr         = '0;
    mem_wdata        = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;

    // rst gates everything combinationally so outputs are zero in the
    // reset cycle itself, not just after the registers clear.
    if (!rst && (state_q == ARB_WAIT) && timer_done) begin
      read_done = 1'b1;
    end else begin
      read_done = 1'b0;
    end

    // Response side.
    if (read_done) begin
      state_d = ARB_IDLE;
      owner_d = OWN_NONE;
      case (owner_q)
        OWN_IF: begin
          if_resp_valid = 1'b1;
          if_resp_data  = mem_read_data;
        end
        OWN_DM: begin
          dm_resp_valid = 1'b1;
          dm_resp_data  = mem_read_data;
        end
        default: begin
          if_resp_valid = 1'b0;
          dm_resp_valid = 1'b0;
        end
      endcase
    end else if (!rst && store_ack_q) begin
      dm_resp_valid = 1'b1;
    end else begin
      dm_resp_valid = 1'b0;
    end

    // Grants are taken when idle or in the completion cycle of a read.
    if (!rst && !init_q && ((state_q == ARB_IDLE) || read_done)) begin
      grant_en = 1'b1;
    end else begin
      grant_en = 1'b0;
    end

    if (grant_en && if_req_valid && (!dm_req_valid || (starve_q == STARVE_MAX))) begin
      grant_if = 1'b1;
    end else if (grant_en && dm_req_valid) begin
      grant_dm = 1'b1;
    end else begin
      grant_if = 1'b0;
      grant_dm = 1'b0;
    end

    // Issue side.
    if (grant_if) begin
      if_req_ready    = 1'b1;
      mem_addr        = if_req_addr;
      mem_read_enable = 1'b1;
      state_d         = ARB_WAIT;
      owner_d         = OWN_IF;
      timer_load      = 1'b1;
    end else if (grant_dm) begin
      dm_req_ready = 1'b1;
      mem_addr     = dm_req_addr;
      if (dm_req_write) begin
        // Store finishes in the grant cycle; only the ack is deferred.
        mem_wdata        = dm_req_wdata;
        mem_write_enable = 1'b1;
        store_ack_d      = 1'b1;
      end else begin
        mem_read_enable = 1'b1;
        state_d         = ARB_WAIT;
        owner_d         = OWN_DM;
        timer_load      = 1'b1;
      end
    end else begin
      mem_read_enable = 1'b0;
    end

    // Starve counter counts data wins only while fetch is waiting.
    if (!if_req_valid) begin
      starve_d = '0;
    end else if (grant_if) begin
      starve_d = '0;
    end else if (grant_dm && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SC_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      store_ack_q <= 1'b0;
      init_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      store_ack_q <= store_ack_d;
      init_q      <= init_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. dut_a uses MEM_LATENCY=2, dut_b
//   uses MEM_LATENCY=1; both use STARVE_LIMIT=4. A small memory model returns
//   mem_fn(addr) the programmed number of cycles after each read strobe.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut_a (latency 2)
  logic        if_req_valid_a, if_req_ready_a, if_resp_valid_a;
  logic [31:0] if_req_addr_a, if_resp_data_a;
  logic        dm_req_valid_a, dm_req_write_a, dm_req_ready_a, dm_resp_valid_a;
  logic [31:0] dm_req_addr_a, dm_req_wdata_a, dm_resp_data_a;
  logic [31:0] mem_addr_a, mem_wdata_a, mem_read_data_a;
  logic        mem_read_enable_a, mem_write_enable_a;

  // dut_b (latency 1)
  logic        if_req_valid_b, if_req_ready_b, if_resp_valid_b;
  logic [31:0] if_req_addr_b, if_resp_data_b;
  logic        dm_req_valid_b, dm_req_write_b, dm_req_ready_b, dm_resp_valid_b;
  logic [31:0] dm_req_addr_b, dm_req_wdata_b, dm_resp_data_b;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_read_data_b;
  logic        mem_read_enable_b, mem_write_enable_b;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid_a), .if_req_addr(if_req_addr_a), .if_req_ready(if_req_ready_a),
    .if_resp_valid(if_resp_valid_a), .if_resp_data(if_resp_data_a),
    .dm_req_valid(dm_req_valid_a), .dm_req_write(dm_req_write_a), .dm_req_addr(dm_req_addr_a),
    .dm_req_wdata(dm_req_wdata_a), .dm_req_ready(dm_req_ready_a),
    .dm_resp_valid(dm_resp_valid_a), .dm_resp_data(dm_resp_data_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_read_enable(mem_read_enable_a),
    .mem_write_enable(mem_write_enable_a), .mem_read_data(mem_read_data_a)
  );

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid_b), .if_req_addr(if_req_addr_b), .if_req_ready(if_req_ready_b),
    .if_resp_valid(if_resp_valid_b), .if_resp_data(if_resp_data_b),
    .dm_req_valid(dm_req_valid_b), .dm_req_write(dm_req_write_b), .dm_req_addr(dm_req_addr_b),
    .dm_req_wdata(dm_req_wdata_b), .dm_req_ready(dm_req_ready_b),
    .dm_resp_valid(dm_resp_valid_b), .dm_resp_data(dm_resp_data_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_read_enable(mem_read_enable_b),
    .mem_write_enable(mem_write_enable_b), .mem_read_data(mem_read_data_b)
  );

  // Memory contents: one special word, everything else derived from address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : (32'hA5A5_0000 ^ a);
  endfunction

  logic [31:0] p1_a, p2_a, p1_b;
  always @(posedge clk) begin
    p1_a <= mem_read_enable_a ? mem_addr_a : 32'h0;
    p2_a <= p1_a;
    p1_b <= mem_read_enable_b ? mem_addr_b : 32'h0;
  end
  assign mem_read_data_a = mem_fn(p2_a);
  assign mem_read_data_b = mem_fn(p1_b);

  logic any_out_a;
  assign any_out_a = |{if_req_ready_a, if_resp_valid_a, if_resp_data_a, dm_req_ready_a,
                       dm_resp_valid_a, dm_resp_data_a, mem_addr_a, mem_wdata_a,
                       mem_read_enable_a, mem_write_enable_a};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req_valid_a = 1'b1; if_req_addr_a = 32'h10;
    dm_req_valid_a = 1'b1; dm_req_write_a = 1'b0; dm_req_addr_a = 32'h80; dm_req_wdata_a = 32'h0;
    if_req_valid_b = 1'b0; if_req_addr_b = 32'h0;
    dm_req_valid_b = 1'b0; dm_req_write_b = 1'b0; dm_req_addr_b = 32'h0; dm_req_wdata_b = 32'h0;

    // Reset cycles with both requesters pending: everything quiet.
    next_cycle(); settle();
    check("rst_cycle_quiet", 64'(any_out_a), 64'd0);
    next_cycle(); settle();
    check("rst_cycle2_quiet", 64'(any_out_a), 64'd0);
    next_cycle(); rst = 1'b0; dm_req_valid_a = 1'b0; settle();
    check("post_rst_quiet", 64'(any_out_a), 64'd0);

    // Fetch only, 0x10 -> 0xDEADBEEF, back-to-back fetch at T+2.
    next_cycle(); settle();
    check("f_ready_T", 64'(if_req_ready_a), 64'd1);
    check("f_re_T", 64'(mem_read_enable_a), 64'd1);
    check("f_we_T", 64'(mem_write_enable_a), 64'd0);
    check("f_addr_T", 64'(mem_addr_a), 64'h10);
    check("f_dmready_T", 64'(dm_req_ready_a), 64'd0);
    next_cycle(); if_req_addr_a = 32'h14; settle();
    check("f_wait_ready", 64'(if_req_ready_a), 64'd0);
    check("f_wait_re", 64'(mem_read_enable_a), 64'd0);
    check("f_wait_resp", 64'(if_resp_valid_a), 64'd0);
    check("f_wait_addr", 64'(mem_addr_a), 64'd0);
    next_cycle(); settle();
    check("f_resp_valid", 64'(if_resp_valid_a), 64'd1);
    check("f_resp_data", 64'(if_resp_data_a), 64'hDEAD_BEEF);
    check("f_b2b_ready", 64'(if_req_ready_a), 64'd1);
    check("f_b2b_addr", 64'(mem_addr_a), 64'h14);
    check("f_dm_resp_data0", 64'(dm_resp_data_a), 64'd0);
    next_cycle(); if_req_valid_a = 1'b0; settle();
    check("f2_wait_resp", 64'(if_resp_valid_a), 64'd0);
    next_cycle(); settle();
    check("f2_resp_valid", 64'(if_resp_valid_a), 64'd1);
    check("f2_resp_data", 64'(if_resp_data_a), 64'hA5A5_0014);
    check("f2_dm_quiet", 64'(dm_resp_valid_a), 64'd0);

    // Same-cycle fetch 0x0 and store 0x40/0x55: store first.
    next_cycle();
    if_req_valid_a = 1'b1; if_req_addr_a = 32'h0;
    dm_req_valid_a = 1'b1; dm_req_write_a = 1'b1; dm_req_addr_a = 32'h40; dm_req_wdata_a = 32'h55;
    settle();
    check("s_dm_ready", 64'(dm_req_ready_a), 64'd1);
    check("s_if_ready", 64'(if_req_ready_a), 64'd0);
    check("s_we", 64'(mem_write_enable_a), 64'd1);
    check("s_re", 64'(mem_read_enable_a), 64'd0);
    check("s_wdata", 64'(mem_wdata_a), 64'h55);
    check("s_addr", 64'(mem_addr_a), 64'h40);
    next_cycle(); dm_req_valid_a = 1'b0; dm_req_write_a = 1'b0; dm_req_wdata_a = 32'h0; settle();
    check("s_ack_valid", 64'(dm_resp_valid_a), 64'd1);
    check("s_ack_data", 64'(dm_resp_data_a), 64'd0);
    check("s_f_ready", 64'(if_req_ready_a), 64'd1);
    check("s_f_re", 64'(mem_read_enable_a), 64'd1);
    check("s_f_wdata0", 64'(mem_wdata_a), 64'd0);
    next_cycle(); if_req_valid_a = 1'b0; settle();
    check("s_ack_pulse", 64'(dm_resp_valid_a), 64'd0);
    next_cycle(); settle();
    check("s_f_resp", 64'(if_resp_valid_a), 64'd1);
    check("s_f_data", 64'(if_resp_data_a), 64'hA5A5_0000);

    // Continuous loads with fetch held: 4 data grants, then fetch.
    next_cycle();
    if_req_valid_a = 1'b1; if_req_addr_a = 32'h200;
    dm_req_valid_a = 1'b1; dm_req_write_a = 1'b0; dm_req_addr_a = 32'h100;
    settle();
    for (int g = 0; g < 5; g++) begin
      if (g > 0) begin
        check("st_dm_resp", 64'(dm_resp_valid_a), 64'd1);
        check("st_dm_data", 64'(dm_resp_data_a), 64'(mem_fn(32'h100 + 32'(4 * (g - 1)))));
      end
      check("st_if_ready", 64'(if_req_ready_a), (g == 4) ? 64'd1 : 64'd0);
      check("st_dm_ready", 64'(dm_req_ready_a), (g == 4) ? 64'd0 : 64'd1);
      check("st_addr", 64'(mem_addr_a), (g == 4) ? 64'h200 : 64'(32'h100 + 32'(4 * g)));
      next_cycle();
      if (g == 4) begin
        if_req_valid_a = 1'b0;
        dm_req_valid_a = 1'b0;
      end else begin
        dm_req_addr_a = dm_req_addr_a + 32'd4;
      end
      settle();
      check("st_wait_noready", 64'({if_req_ready_a, dm_req_ready_a}), 64'd0);
      next_cycle(); settle();
    end
    check("st_if_resp", 64'(if_resp_valid_a), 64'd1);
    check("st_if_data", 64'(if_resp_data_a), 64'hA5A5_0200);
    check("st_no_dm_resp", 64'(dm_resp_valid_a), 64'd0);
    check("st_starve_clr", 64'(dut_a.starve_q), 64'd0);

    // Load in flight, reset at T+1: response dropped.
    next_cycle();
    dm_req_valid_a = 1'b1; dm_req_write_a = 1'b0; dm_req_addr_a = 32'h300;
    settle();
    check("r_load_ready", 64'(dm_req_ready_a), 64'd1);
    check("r_load_re", 64'(mem_read_enable_a), 64'd1);
    next_cycle(); rst = 1'b1; dm_req_valid_a = 1'b0; if_req_valid_a = 1'b1; if_req_addr_a = 32'h20; settle();
    check("r_rst_quiet", 64'(any_out_a), 64'd0);
    next_cycle(); rst = 1'b0; settle();
    check("r_T2_quiet", 64'(any_out_a), 64'd0);
    check("r_T2_no_resp", 64'(dm_resp_valid_a), 64'd0);
    next_cycle(); settle();
    check("r_f_ready", 64'(if_req_ready_a), 64'd1);
    check("r_f_addr", 64'(mem_addr_a), 64'h20);
    next_cycle(); if_req_valid_a = 1'b0; settle();
    check("r_f_wait", 64'({if_resp_valid_a, dm_resp_valid_a}), 64'd0);
    next_cycle(); settle();
    check("r_f_resp", 64'(if_resp_valid_a), 64'd1);
    check("r_f_data", 64'(if_resp_data_a), 64'hA5A5_0020);
    check("r_dm_quiet", 64'(dm_resp_valid_a), 64'd0);

    // Idle: no strobes, no ready, for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      next_cycle(); settle();
      check("idle_a", 64'({mem_read_enable_a, mem_write_enable_a, if_req_ready_a, dm_req_ready_a}), 64'd0);
      check("idle_b", 64'({mem_read_enable_b, mem_write_enable_b, if_req_ready_b, dm_req_ready_b}), 64'd0);
    end

    // MEM_LATENCY=1: alternate load / fetch, one grant per cycle.
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      if (k % 2 == 0) begin
        dm_req_valid_b = 1'b1; dm_req_addr_b = 32'h400 + 32'(4 * k);
        if_req_valid_b = 1'b0;
      end else begin
        if_req_valid_b = 1'b1; if_req_addr_b = 32'h500 + 32'(4 * k);
        dm_req_valid_b = 1'b0;
      end
      settle();
      check("l1_ready", 64'({if_req_ready_b, dm_req_ready_b}), (k % 2 == 0) ? 64'd1 : 64'd2);
      check("l1_re", 64'(mem_read_enable_b), 64'd1);
      check("l1_addr", 64'(mem_addr_b),
            (k % 2 == 0) ? 64'(32'h400 + 32'(4 * k)) : 64'(32'h500 + 32'(4 * k)));
      if (k > 0) begin
        if ((k - 1) % 2 == 0) begin
          check("l1_dm_resp", 64'({dm_resp_valid_b, if_resp_valid_b}), 64'd2);
          check("l1_dm_data", 64'(dm_resp_data_b), 64'(mem_fn(32'h400 + 32'(4 * (k - 1)))));
          check("l1_if_data0", 64'(if_resp_data_b), 64'd0);
        end else begin
          check("l1_if_resp", 64'({dm_resp_valid_b, if_resp_valid_b}), 64'd1);
          check("l1_if_data", 64'(if_resp_data_b), 64'(mem_fn(32'h500 + 32'(4 * (k - 1)))));
          check("l1_dm_data0", 64'(dm_resp_data_b), 64'd0);
        end
      end
    end
    next_cycle(); if_req_valid_b = 1'b0; dm_req_valid_b = 1'b0; settle();
    check("l1_last_resp", 64'({dm_resp_valid_b, if_resp_valid_b}), 64'd1);
    check("l1_last_data", 64'(if_resp_data_b), 64'hA5A5_0514);
    check("l1_last_noready", 64'({if_req_ready_b, dm_req_ready_b}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the fetch requester (PC-driven) and the load/store requester.
- Allows the CPU to run from a unified instruction/data memory.
- Sequences each memory transaction: grant, issue, wait a fixed read latency, route the response back.
- Uses fixed data-over-fetch priority, with a starvation limit that protects fetch.

Parameters:
DATA_WIDTH, 32, width of the memory data word
ADDR_WIDTH, 32, width of the byte address
MEM_LATENCY, 2, cycles from read issue to valid mem_read_data (legal range 1 to 15)
STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced to win (minimum 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req_valid  in  1  fetch read request
if_req_addr  in  ADDR_WIDTH  fetch address
if_req_ready  out  1  fetch request accepted this cycle
if_resp_valid  out  1  fetch read data valid (one-cycle pulse)
if_resp_data  out  DATA_WIDTH  fetch read data
dm_req_valid  in  1  load/store request
dm_req_write  in  1  1 = store, 0 = load
dm_req_addr  in  ADDR_WIDTH  data address
dm_req_wdata  in  DATA_WIDTH  store data
dm_req_ready  out  1  data request accepted this cycle
dm_resp_valid  out  1  load data valid or store acknowledge (one-cycle pulse)
dm_resp_data  out  DATA_WIDTH  load data; 0 on a store acknowledge
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_read_enable  out  1  memory read strobe
mem_write_enable  out  1  memory write strobe
mem_read_data  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after the read strobe

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - State goes to ARB_IDLE, owner to OWN_NONE, latency counter and starve counter to 0.
  - All outputs are 0 in the reset cycle and in the first cycle after it.
  - rst during ARB_WAIT drops the in-flight transaction; no response is ever produced for it.
- Handshake: each requester holds valid, addr, write and wdata stable until ready is seen high.
  - ready is combinational and is high only in the grant cycle.
  - At most one transaction is outstanding at any time.
- Grant rule, evaluated in ARB_IDLE (or in the completion cycle, see below):
  - If only one valid is high, that requester is granted.
  - If both are high, data is granted unless starve_cnt == STARVE_LIMIT, in which case fetch is granted.
- Grant cycle T:
  - The winner's ready = 1.
  - mem_addr and mem_wdata are driven from the winner; mem_wdata = 0 for fetch.
  - mem_read_enable = 1 for fetch or load; mem_write_enable = 1 for store. The two strobes are never both high.
  - When no grant occurs, mem_* outputs are 0.
- Load or fetch:
  - Go to ARB_WAIT and load the counter with MEM_LATENCY-1.
  - The counter decrements each cycle.
  - At T+MEM_LATENCY, assert the owner's resp_valid for one cycle, with resp_data = mem_read_data.
- Store:
  - The write completes at T.
  - dm_resp_valid pulses at T+1 with dm_resp_data = 0.
- Completion cycle:
  - The grant rule is re-evaluated in the same cycle as the response, so back-to-back grants are allowed.
  - Read throughput is one per MEM_LATENCY cycles; store throughput is one per cycle.
  - MEM_LATENCY = 1 behaves identically to a store for pipelining.
- resp_data of the non-owner is 0. if_resp_valid and dm_resp_valid are never high together.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each data grant while if_req_valid = 1.
  - Clears on a fetch grant, or in any cycle where if_req_valid = 0.
- A requester that drops valid before being granted is legal; nothing is issued for it.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum state_t {ARB_IDLE, ARB_WAIT}
  - typedef enum owner_t {OWN_NONE, OWN_IF, OWN_DM}
  - localparam LAT_CNT_WIDTH = 4
- Sub-module mem_arb_timer: a loadable down-counter with a done flag, used for the read latency.
- Grant logic and starve counter live in the top-level block.

Test Plan (MEM_LATENCY=2, STARVE_LIMIT=4 unless noted):
- Fetch only, addr 0x10, memory word 0xDEADBEEF:
  - if_req_ready at T, mem_read_enable at T.
  - if_resp_valid at T+2 with data 0xDEADBEEF; a new fetch is granted at T+2.
- Same-cycle fetch 0x0 and store 0x40 (wdata 0x55):
  - Store granted first, with mem_write_enable and mem_wdata 0x55.
  - dm_resp_valid at T+1; fetch granted at T+1.
- Continuous loads with fetch valid held:
  - Exactly 4 data grants occur, then the 5th grant goes to fetch.
  - starve_cnt returns to 0 after the fetch grant.
- Load in flight, rst asserted at T+1:
  - No dm_resp_valid is produced; all outputs are 0 through T+2.
  - A fetch after reset is served normally.
- MEM_LATENCY=1, alternating load/fetch every cycle:
  - One grant per cycle; each response arrives the cycle after its grant, routed to the correct owner.
- Idle with no valids: mem_read_enable = mem_write_enable = 0 and both ready outputs are 0 for 10 cycles.
